// File: rtl/pipelined_control_unit.sv
// Main decoder for a 5-stage MIPS pipeline. It decodes the ID opcode into a
// control bundle, registers that bundle into ID/EX, and then carries it
// through EX/MEM and MEM/WB. A stall inserts a bubble into EX and a flush
// squashes EX and MEM. Illegal opcodes are flagged combinationally, and a
// saturating counter records the ones that actually issue.
module pipelined_control_unit #(
   parameter int   OPCODE_W     = 6,
   parameter int   ALUOP_W      = 2,
   parameter logic SUPPORT_ADDI = 1'b1,
   parameter logic SUPPORT_BNE  = 1'b1,
   parameter int   CNT_W        = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                id_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                stall,
   input  logic                flush,
   output logic                id_jump,
   output logic                id_illegal,
   output logic                ex_valid,
   output logic                ex_reg_dst,
   output logic                ex_alu_src,
   output logic [ALUOP_W-1:0]  ex_alu_op,
   output logic                ex_branch,
   output logic                ex_beq_flag,
   output logic                mem_valid,
   output logic                mem_mem_read,
   output logic                mem_mem_write,
   output logic                wb_valid,
   output logic                wb_reg_write,
   output logic                wb_mem_to_reg,
   output logic [CNT_W-1:0]    illegal_cnt
);

   // Control bundle layout (the ALUOp field sits in the upper bits).
   localparam int BW           = ALUOP_W + 8;
   localparam int B_REG_DST    = 0;
   localparam int B_ALU_SRC    = 1;
   localparam int B_BRANCH     = 2;
   localparam int B_BEQ        = 3;
   localparam int B_MEM_READ   = 4;
   localparam int B_MEM_WRITE  = 5;
   localparam int B_REG_WRITE  = 6;
   localparam int B_MEM_TO_REG = 7;
   localparam int B_ALU_OP     = 8;

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);

   localparam logic [BW-1:0]    BUBBLE  = {BW{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Opcode legality. ADDI and BNE exist only when the matching option is enabled.
   function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
      logic ok;
      case (op)
         OP_R, OP_LW, OP_SW, OP_J, OP_BEQ: ok = 1'b1;
         OP_ADDI:                          ok = SUPPORT_ADDI;
         OP_BNE:                           ok = SUPPORT_BNE;
         default:                          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Opcode to control bundle. Unsupported and illegal opcodes give an all-zero bundle.
   function automatic logic [BW-1:0] decode(input logic [OPCODE_W-1:0] op);
      logic [BW-1:0] b;
      b = BUBBLE;
      case (op)
         OP_R: begin
            b[B_REG_DST]               = 1'b1;
            b[B_REG_WRITE]             = 1'b1;
            b[B_ALU_OP +: ALUOP_W]     = ALUOP_W'(2'b10);
         end
         OP_ADDI: begin
            b[B_ALU_SRC]               = SUPPORT_ADDI;
            b[B_REG_WRITE]             = SUPPORT_ADDI;
         end
         OP_LW: begin
            b[B_ALU_SRC]               = 1'b1;
            b[B_MEM_READ]              = 1'b1;
            b[B_MEM_TO_REG]            = 1'b1;
            b[B_REG_WRITE]             = 1'b1;
         end
         OP_SW: begin
            b[B_ALU_SRC]               = 1'b1;
            b[B_MEM_WRITE]             = 1'b1;
         end
         OP_BEQ: begin
            b[B_BRANCH]                = 1'b1;
            b[B_BEQ]                   = 1'b1;
            b[B_ALU_OP +: ALUOP_W]     = ALUOP_W'(2'b01);
         end
         OP_BNE: begin
            b[B_BRANCH]                = SUPPORT_BNE;
            b[B_ALU_OP +: ALUOP_W]     = SUPPORT_BNE ? ALUOP_W'(2'b01) : ALUOP_W'(2'b00);
         end
         default: b = BUBBLE;
      endcase
      return b;
   endfunction

   logic            legal_s;
   logic            issue_s;
   logic            ex_valid_next_s;
   logic [BW-1:0]   ex_bund_next_s;
   logic            cnt_inc_s;

   logic            ex_valid_r;
   logic [BW-1:0]   ex_bund_r;
   logic            mem_valid_r;
   logic            mem_read_r;
   logic            mem_write_r;
   logic            mem_reg_write_r;
   logic            mem_mem_to_reg_r;
   logic            wb_valid_r;
   logic            wb_reg_write_r;
   logic            wb_mem_to_reg_r;
   logic [CNT_W-1:0] cnt_r;

   // Issue decision and the next ID/EX contents. A J issues as valid with an empty bundle.
   always_comb begin
      legal_s         = is_legal(opcode);
      issue_s         = id_valid & ~stall & ~flush;
      ex_valid_next_s = 1'b0;
      ex_bund_next_s  = BUBBLE;
      if (issue_s & legal_s) begin
         ex_valid_next_s = 1'b1;
         ex_bund_next_s  = decode(opcode);
      end else begin
         ex_valid_next_s = 1'b0;
         ex_bund_next_s  = BUBBLE;
      end
      cnt_inc_s = issue_s & ~legal_s & (cnt_r != CNT_MAX);
   end

   // ID/EX register: decoded bundle on issue, bubble otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid_r <= 1'b0;
         ex_bund_r  <= BUBBLE;
      end else begin
         ex_valid_r <= ex_valid_next_s;
         ex_bund_r  <= ex_bund_next_s;
      end
   end

   // EX/MEM register: a taken branch in EX squashes what would move into MEM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_valid_r      <= 1'b0;
         mem_read_r       <= 1'b0;
         mem_write_r      <= 1'b0;
         mem_reg_write_r  <= 1'b0;
         mem_mem_to_reg_r <= 1'b0;
      end else if (flush) begin
         mem_valid_r      <= 1'b0;
         mem_read_r       <= 1'b0;
         mem_write_r      <= 1'b0;
         mem_reg_write_r  <= 1'b0;
         mem_mem_to_reg_r <= 1'b0;
      end else begin
         mem_valid_r      <= ex_valid_r;
         mem_read_r       <= ex_bund_r[B_MEM_READ];
         mem_write_r      <= ex_bund_r[B_MEM_WRITE];
         mem_reg_write_r  <= ex_bund_r[B_REG_WRITE];
         mem_mem_to_reg_r <= ex_bund_r[B_MEM_TO_REG];
      end
   end

   // MEM/WB register: always advances, because MEM is past the point a flush can touch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid_r      <= 1'b0;
         wb_reg_write_r  <= 1'b0;
         wb_mem_to_reg_r <= 1'b0;
      end else begin
         wb_valid_r      <= mem_valid_r;
         wb_reg_write_r  <= mem_reg_write_r;
         wb_mem_to_reg_r <= mem_mem_to_reg_r;
      end
   end

   // Saturating count of illegal opcodes that actually issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
         cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign id_jump       = id_valid & (opcode == OP_J);
   assign id_illegal    = id_valid & ~legal_s;
   assign ex_valid      = ex_valid_r;
   assign ex_reg_dst    = ex_bund_r[B_REG_DST];
   assign ex_alu_src    = ex_bund_r[B_ALU_SRC];
   assign ex_alu_op     = ex_bund_r[B_ALU_OP +: ALUOP_W];
   assign ex_branch     = ex_bund_r[B_BRANCH];
   assign ex_beq_flag   = ex_bund_r[B_BEQ];
   assign mem_valid     = mem_valid_r;
   assign mem_mem_read  = mem_read_r;
   assign mem_mem_write = mem_write_r;
   assign wb_valid      = wb_valid_r;
   assign wb_reg_write  = wb_reg_write_r;
   assign wb_mem_to_reg = wb_mem_to_reg_r;
   assign illegal_cnt   = cnt_r;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit. Two instances share one stimulus stream:
// u_a uses the default parameters, and u_b uses CNT_W=2 with ADDI and BNE
// disabled. A table-driven model records the issued bundle and the flush
// flag at every edge, and stage latency turns that record into expected
// EX/MEM/WB values. Directed literal checks pin the model on known sequences.
module tb_pipelined_control_unit;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid;
   logic [5:0] opcode;
   logic       stall;
   logic       flush;

   logic       id_jump_a, id_illegal_a, ex_valid_a, ex_reg_dst_a, ex_alu_src_a, ex_branch_a, ex_beq_a;
   logic [1:0] ex_alu_op_a;
   logic       mem_valid_a, mem_read_a, mem_write_a, wb_valid_a, wb_reg_write_a, wb_m2r_a;
   logic [7:0] cnt_a;
   logic       id_jump_b, id_illegal_b, ex_valid_b, ex_reg_dst_b, ex_alu_src_b, ex_branch_b, ex_beq_b;
   logic [1:0] ex_alu_op_b;
   logic       mem_valid_b, mem_read_b, mem_write_b, wb_valid_b, wb_reg_write_b, wb_m2r_b;
   logic [1:0] cnt_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipelined_control_unit u_a (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opcode(opcode),
      .stall(stall), .flush(flush), .id_jump(id_jump_a), .id_illegal(id_illegal_a),
      .ex_valid(ex_valid_a), .ex_reg_dst(ex_reg_dst_a), .ex_alu_src(ex_alu_src_a),
      .ex_alu_op(ex_alu_op_a), .ex_branch(ex_branch_a), .ex_beq_flag(ex_beq_a),
      .mem_valid(mem_valid_a), .mem_mem_read(mem_read_a), .mem_mem_write(mem_write_a),
      .wb_valid(wb_valid_a), .wb_reg_write(wb_reg_write_a), .wb_mem_to_reg(wb_m2r_a),
      .illegal_cnt(cnt_a));

   pipelined_control_unit #(.CNT_W(2), .SUPPORT_ADDI(1'b0), .SUPPORT_BNE(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .opcode(opcode),
      .stall(stall), .flush(flush), .id_jump(id_jump_b), .id_illegal(id_illegal_b),
      .ex_valid(ex_valid_b), .ex_reg_dst(ex_reg_dst_b), .ex_alu_src(ex_alu_src_b),
      .ex_alu_op(ex_alu_op_b), .ex_branch(ex_branch_b), .ex_beq_flag(ex_beq_b),
      .mem_valid(mem_valid_b), .mem_mem_read(mem_read_b), .mem_mem_write(mem_write_b),
      .wb_valid(wb_valid_b), .wb_reg_write(wb_reg_write_b), .wb_mem_to_reg(wb_m2r_b),
      .illegal_cnt(cnt_b));

   // ---------------- reference model ----------------
   typedef struct packed {
      logic       valid;
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       branch;
      logic       beq;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } bund_t;

   localparam int DEPTH = 8192;
   bund_t ia [DEPTH];
   bund_t ib [DEPTH];
   logic  fl [DEPTH];
   int    n = 0;
   int    mcnt_a = 0;
   int    mcnt_b = 0;
   logic  chk_en = 1'b0;

   // Instruction-table view of an opcode: valid=0 means the opcode is illegal for that build.
   function automatic bund_t model_decode(input logic [5:0] op, input bit addi_en, input bit bne_en);
      bund_t b;
      b = '0;
      b.valid = 1'b1;
      case (op)
         6'o00: begin b.reg_dst = 1'b1; b.reg_write = 1'b1; b.alu_op = 2'd2; end
         6'o10: if (addi_en) begin b.alu_src = 1'b1; b.reg_write = 1'b1; end else b = '0;
         6'o43: begin b.alu_src = 1'b1; b.mem_read = 1'b1; b.mem_to_reg = 1'b1; b.reg_write = 1'b1; end
         6'o53: begin b.alu_src = 1'b1; b.mem_write = 1'b1; end
         6'o02: b.valid = 1'b1;
         6'o04: begin b.branch = 1'b1; b.beq = 1'b1; b.alu_op = 2'd1; end
         6'o05: if (bne_en) begin b.branch = 1'b1; b.alu_op = 2'd1; end else b = '0;
         default: b = '0;
      endcase
      return b;
   endfunction

   // Reset wipes everything in flight, along with both counters.
   always @(negedge reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
         ia[k] = '0; ib[k] = '0; fl[k] = 1'b0;
      end
      mcnt_a = 0;
      mcnt_b = 0;
   end

   // Record at each edge what issued and whether EX->MEM was squashed.
   always @(posedge clk) begin
      bund_t da, db;
      logic  iss;
      n = n + 1;
      iss = reset_n && id_valid && !stall && !flush;
      da  = model_decode(opcode, 1'b1, 1'b1);
      db  = model_decode(opcode, 1'b0, 1'b0);
      ia[n+2] = iss ? da : '0;
      ib[n+2] = iss ? db : '0;
      fl[n+2] = reset_n ? flush : 1'b0;
      if (iss && !da.valid && mcnt_a < 255) mcnt_a = mcnt_a + 1;
      if (iss && !db.valid && mcnt_b < 3)   mcnt_b = mcnt_b + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      bund_t ea, ma, wa, eb, mb, wb;
      bit    la, lb, jj;
      if (chk_en) begin
         ea = ia[n+2]; ma = fl[n+2] ? '0 : ia[n+1]; wa = fl[n+1] ? '0 : ia[n];
         eb = ib[n+2]; mb = fl[n+2] ? '0 : ib[n+1]; wb = fl[n+1] ? '0 : ib[n];
         la = model_decode(opcode, 1'b1, 1'b1).valid;
         lb = model_decode(opcode, 1'b0, 1'b0).valid;
         jj = id_valid && (opcode == 6'o02);
         chk("a_ex", {25'd0, ex_valid_a, ex_reg_dst_a, ex_alu_src_a, ex_alu_op_a, ex_branch_a, ex_beq_a},
             {25'd0, ea.valid, ea.reg_dst, ea.alu_src, ea.alu_op, ea.branch, ea.beq});
         chk("a_mem", {29'd0, mem_valid_a, mem_read_a, mem_write_a}, {29'd0, ma.valid, ma.mem_read, ma.mem_write});
         chk("a_wb", {29'd0, wb_valid_a, wb_reg_write_a, wb_m2r_a}, {29'd0, wa.valid, wa.reg_write, wa.mem_to_reg});
         chk("a_cnt", {24'd0, cnt_a}, mcnt_a);
         chk("a_comb", {30'd0, id_jump_a, id_illegal_a}, {30'd0, jj, id_valid && !la});
         chk("b_ex", {25'd0, ex_valid_b, ex_reg_dst_b, ex_alu_src_b, ex_alu_op_b, ex_branch_b, ex_beq_b},
             {25'd0, eb.valid, eb.reg_dst, eb.alu_src, eb.alu_op, eb.branch, eb.beq});
         chk("b_mem", {29'd0, mem_valid_b, mem_read_b, mem_write_b}, {29'd0, mb.valid, mb.mem_read, mb.mem_write});
         chk("b_wb", {29'd0, wb_valid_b, wb_reg_write_b, wb_m2r_b}, {29'd0, wb.valid, wb.reg_write, wb.mem_to_reg});
         chk("b_cnt", {30'd0, cnt_b}, mcnt_b);
         chk("b_comb", {30'd0, id_jump_b, id_illegal_b}, {30'd0, jj, id_valid && !lb});
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [5:0] R = 6'o00, ADDI = 6'o10, LW = 6'o43, SW = 6'o53,
                          J = 6'o02, BEQ = 6'o04, BNE = 6'o05, BAD = 6'o77;

   task automatic cyc(input logic v, input logic [5:0] op, input logic st, input logic f);
      @(negedge clk);
      #2;
      id_valid = v; opcode = op; stall = st; flush = f;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      @(negedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic random_phase(input int cycles);
      logic [5:0] tbl [8];
      tbl = '{R, ADDI, LW, SW, J, BEQ, BNE, BAD};
      for (int i = 0; i < cycles; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
         cyc($urandom_range(0, 9) < 8, op, $urandom_range(0, 9) < 2, $urandom_range(0, 99) < 15);
      end
   endtask

   initial begin
      reset_n = 1'b0; id_valid = 1'b0; opcode = R; stall = 1'b0; flush = 1'b0;
      #23;
      chk_en = 1'b1;
      chk("rst_ex_valid", {31'd0, ex_valid_a}, 32'd0);
      chk("rst_cnt", {24'd0, cnt_a}, 32'd0);
      do_reset();

      // LW through all stages
      cyc(1'b1, LW, 1'b0, 1'b0);
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("lw_ex", {28'd0, ex_valid_a, ex_alu_src_a, ex_alu_op_a}, {28'd0, 4'b1100});
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("lw_mem", {30'd0, mem_valid_a, mem_read_a}, 32'd3);
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("lw_wb", {29'd0, wb_valid_a, wb_reg_write_a, wb_m2r_a}, 32'd7);

      // BEQ held by a stall, then issued
      cyc(1'b1, BEQ, 1'b1, 1'b0);
      cyc(1'b1, BEQ, 1'b0, 1'b0);
      chk("beq_stall", {25'd0, ex_valid_a, ex_reg_dst_a, ex_alu_src_a, ex_alu_op_a, ex_branch_a, ex_beq_a}, 32'd0);
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("beq_ex", {28'd0, ex_branch_a, ex_beq_a, ex_alu_op_a}, {28'd0, 4'b1101});

      // Flush with LW in EX and SW in ID; the older R still retires
      cyc(1'b1, R, 1'b0, 1'b0);
      cyc(1'b1, LW, 1'b0, 1'b0);
      cyc(1'b1, SW, 1'b0, 1'b1);
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("flush_mem_ex", {29'd0, mem_read_a, mem_valid_a, ex_valid_a}, 32'd0);
      chk("flush_wb", {29'd0, wb_valid_a, wb_reg_write_a, wb_m2r_a}, 32'd6);

      random_phase(400);

      // Asynchronous reset between edges, in the middle of an R stream
      cyc(1'b1, R, 1'b0, 1'b0);
      cyc(1'b1, R, 1'b0, 1'b0);
      cyc(1'b1, R, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst", {22'd0, ex_valid_a, ex_reg_dst_a, mem_valid_a, wb_valid_a, wb_reg_write_a, cnt_a, cnt_b},
          32'd0);
      cyc(1'b1, R, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("post_rst_r", {29'd0, ex_reg_dst_a, ex_alu_op_a}, 32'd6);

      // BNE on the build without it, then J
      cyc(1'b1, BNE, 1'b0, 1'b0);
      #1;
      chk("bne_b_illegal", {30'd0, id_illegal_b, id_illegal_a}, 32'd2);
      cyc(1'b1, J, 1'b0, 1'b0);
      #1;
      chk("j_comb", {31'd0, id_jump_b}, 32'd1);
      chk("bne_b_ex", {28'd0, ex_valid_b, ex_valid_a, cnt_b}, {28'd0, 4'b0101});
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("j_ex", {25'd0, ex_valid_b, ex_reg_dst_b, ex_alu_src_b, ex_alu_op_b, ex_branch_b, ex_beq_b}, 32'h40);

      // Saturating illegal counter on the 2-bit build
      do_reset();
      cyc(1'b1, BAD, 1'b0, 1'b0);
      #1;
      chk("bad_illegal", {31'd0, id_illegal_b}, 32'd1);
      cyc(1'b1, BAD, 1'b0, 1'b0);
      chk("cnt1", {30'd0, cnt_b}, 32'd1);
      cyc(1'b1, BAD, 1'b1, 1'b0);
      chk("cnt2", {30'd0, cnt_b}, 32'd2);
      cyc(1'b1, BAD, 1'b0, 1'b0);
      chk("cnt_stalled", {30'd0, cnt_b}, 32'd2);
      cyc(1'b1, BAD, 1'b0, 1'b0);
      chk("cnt3", {30'd0, cnt_b}, 32'd3);
      cyc(1'b0, R, 1'b0, 1'b0);
      chk("cnt_sat", {30'd0, cnt_b}, 32'd3);

      random_phase(400);

      cyc(1'b0, R, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a run that never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

endmodule
